// File: rtl/conv_frame_sequencer_pkg.sv
// Shared constants and types for the convolution frame sequencer.
//   Def*          default frame geometry and watchdog limit
//   DataW         width of the engine result word
//   seq_state_e   sequencer FSM states
//   cnt_width()   counter width for a count range of n (at least 1 bit)
package conv_frame_sequencer_pkg;

    localparam int unsigned DefImageWidth  = 128;
    localparam int unsigned DefImageHeight = 128;
    localparam int unsigned DefFilterWidth  = 3;
    localparam int unsigned DefFilterHeight = 3;
    localparam int unsigned DefTimeoutCyc  = 65536;
    localparam int unsigned DataW          = 13;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain,
        StDone,
        StErr
    } seq_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_frame_sequencer_raster_counter.sv
// Raster-order position counter (column fastest, row slowest).
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          return to (0,0); wins over inc_i
//   inc_i          advance one position; wraps to (0,0) after the last one
//   row_o, col_o   current position
//   last_o         current position is (ROWS-1, COLS-1)
module conv_frame_sequencer_raster_counter #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned ROWS  = 4,
    parameter int unsigned COL_W = 2,
    parameter int unsigned ROW_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] col_o,
    output logic             last_o
);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end;

    assign col_end = (col_q == COL_W'(COLS - 1));
    assign last_o  = col_end && (row_q == ROW_W'(ROWS - 1));
    assign row_o   = row_q;
    assign col_o   = col_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = last_o ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame-level controller for the 3-channel convolution engine: loads one RGB frame
// (valid/ready), waits for the engine, and streams the results out with raster coordinates.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i, abort_i     begin frame (IDLE/ERR only) / cancel frame (any state, top priority)
//   pix_valid_i          source pixel available
//   pix_ready_o          sequencer accepts pixels (LOAD)
//   load_en_o            engine load strobe = pix_valid_i & pix_ready_o
//   dp_save_i, dp_e_i    engine result valid / result word
//   out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o   registered result stream
//   busy_o               not idle
//   frame_done_o         one-cycle pulse once the frame is fully drained
//   timeout_err_o        sticky watchdog flag; cleared by accepted start or reset
module conv_frame_sequencer
    import conv_frame_sequencer_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH   = DefImageWidth,
    parameter int unsigned IMAGE_HEIGHT  = DefImageHeight,
    parameter int unsigned FILTER_WIDTH  = DefFilterWidth,
    parameter int unsigned FILTER_HEIGHT = DefFilterHeight,
    parameter int unsigned TIMEOUT_CYC   = DefTimeoutCyc,
    localparam int unsigned ColW = cnt_width(IMAGE_WIDTH),
    localparam int unsigned RowW = cnt_width(IMAGE_HEIGHT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             pix_valid_i,
    output logic             pix_ready_o,
    output logic             load_en_o,
    input  logic             dp_save_i,
    input  logic [DataW-1:0] dp_e_i,
    output logic             out_valid_o,
    output logic [DataW-1:0] out_data_o,
    output logic [RowW-1:0]  out_row_o,
    output logic [ColW-1:0]  out_col_o,
    output logic             out_last_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             timeout_err_o
);

    localparam int unsigned OutW = IMAGE_WIDTH - FILTER_WIDTH + 1;
    localparam int unsigned OutH = IMAGE_HEIGHT - FILTER_HEIGHT + 1;
    localparam int unsigned WdW  = cnt_width(TIMEOUT_CYC);
    localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [WdW-1:0]   wdog_q, wdog_d;
    logic             timeout_err_q, timeout_err_d;
    logic             out_valid_q, out_last_q, frame_done_q;
    logic [DataW-1:0] out_data_q;
    logic [RowW-1:0]  out_row_q;
    logic [ColW-1:0]  out_col_q;

    logic             start_acc, capture, cnt_clr;
    logic             ld_last, dr_last;
    logic [RowW-1:0]  ld_row, dr_row;
    logic [ColW-1:0]  ld_col, dr_col;
    logic             unused_ld_pos;

    assign pix_ready_o = (state_q == StLoad);
    assign load_en_o   = pix_valid_i & pix_ready_o;
    assign busy_o      = (state_q != StIdle);

    assign start_acc = start_i & ~abort_i & ((state_q == StIdle) | (state_q == StErr));
    // The first result may arrive while still in COMPUTE; it is captured, not dropped.
    assign capture   = dp_save_i & ~abort_i & ((state_q == StCompute) | (state_q == StDrain));
    assign cnt_clr   = start_acc | abort_i;

    // Only the end-of-frame flag of the load counter matters.
    assign unused_ld_pos = ^{ld_row, ld_col};

    conv_frame_sequencer_raster_counter #(
        .COLS  (IMAGE_WIDTH),
        .ROWS  (IMAGE_HEIGHT),
        .COL_W (ColW),
        .ROW_W (RowW)
    ) u_load_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (load_en_o),
        .row_o  (ld_row),
        .col_o  (ld_col),
        .last_o (ld_last)
    );

    conv_frame_sequencer_raster_counter #(
        .COLS  (OutW),
        .ROWS  (OutH),
        .COL_W (ColW),
        .ROW_W (RowW)
    ) u_drain_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .inc_i  (capture),
        .row_o  (dr_row),
        .col_o  (dr_col),
        .last_o (dr_last)
    );

    always_comb begin
        state_d       = state_q;
        wdog_d        = '0;
        timeout_err_d = timeout_err_q;
        if (start_acc) begin
            timeout_err_d = 1'b0;
        end
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) state_d = StLoad;
                end
                StLoad: begin
                    if (load_en_o && ld_last) state_d = StCompute;
                end
                StCompute: begin
                    if (dp_save_i) begin
                        state_d = dr_last ? StDone : StDrain;
                    end else if (wdog_q == WdMax) begin
                        state_d       = StErr;
                        timeout_err_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (dp_save_i && dr_last) state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                StErr: begin
                    if (start_i) state_d = StLoad;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            out_data_q    <= '0;
            out_row_q     <= '0;
            out_col_q     <= '0;
        end else begin
            state_q       <= state_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            out_valid_q   <= capture;
            out_last_q    <= capture & dr_last;
            // Registered from DONE, so the pulse lands one cycle after out_last.
            frame_done_q  <= (state_q == StDone) & ~abort_i;
            if (capture) begin
                out_data_q <= dp_e_i;
                out_row_q  <= dr_row;
                out_col_q  <= dr_col;
            end
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_last_o    = out_last_q;
    assign out_data_o    = out_data_q;
    assign out_row_o     = out_row_q;
    assign out_col_o     = out_col_q;
    assign frame_done_o  = frame_done_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Self-checking bench for conv_frame_sequencer on a reduced 6x5 frame (4x3 output),
// watchdog limit 64.
module tb_conv_frame_sequencer;

    localparam int unsigned IW = 6;
    localparam int unsigned IH = 5;
    localparam int unsigned FW = 3;
    localparam int unsigned FH = 3;
    localparam int unsigned TO = 64;
    localparam int OW    = IW - FW + 1;
    localparam int OH    = IH - FH + 1;
    localparam int NLOAD = IW * IH;
    localparam int NOUT  = OW * OH;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i, abort_i, pix_valid_i, dp_save_i;
    logic [12:0] dp_e_i;
    logic        pix_ready_o, load_en_o, out_valid_o, out_last_o;
    logic [12:0] out_data_o;
    logic [2:0]  out_row_o, out_col_o;
    logic        busy_o, frame_done_o, timeout_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    conv_frame_sequencer #(
        .IMAGE_WIDTH   (IW),
        .IMAGE_HEIGHT  (IH),
        .FILTER_WIDTH  (FW),
        .FILTER_HEIGHT (FH),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .pix_valid_i   (pix_valid_i),
        .pix_ready_o   (pix_ready_o),
        .load_en_o     (load_en_o),
        .dp_save_i     (dp_save_i),
        .dp_e_i        (dp_e_i),
        .out_valid_o   (out_valid_o),
        .out_data_o    (out_data_o),
        .out_row_o     (out_row_o),
        .out_col_o     (out_col_o),
        .out_last_o    (out_last_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .timeout_err_o (timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic start;
        logic abort;
        logic pv;
        logic ds;
        logic exp_ready;
        logic exp_le;
        logic exp_busy;
        logic exp_ov;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_frame();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i     = 1'b0;
        pix_valid_i = 1'b0;
        dp_save_i   = 1'b0;
        @(negedge clk_i);
        chk("start_ready", pix_ready_o, 1);
        chk("start_busy", busy_o, 1);
        chk("start_timeout_clr", timeout_err_o, 0);
    endtask

    // abort_at > 0 drives abort together with that accept number.
    task automatic load_frame(input int pct, input int abort_at);
        int acc = 0;
        int n_le = 0;
        int cyc = 0;
        int target;
        target = (abort_at > 0) ? abort_at : NLOAD;
        while (acc < target && cyc < 1000) begin
            @(posedge clk_i); #1;
            pix_valid_i = ($urandom_range(0, 99) < pct);
            abort_i     = pix_valid_i && (acc + 1 == abort_at);
            @(negedge clk_i);
            chk("load_ready", pix_ready_o, 1);
            chk("load_en", load_en_o, pix_valid_i);
            if (load_en_o) n_le++;
            if (pix_valid_i) acc++;
            cyc++;
        end
        chk("load_accepts", acc, target);
        chk("load_en_count", n_le, target);
        @(posedge clk_i); #1;
        abort_i     = 1'b0;
        pix_valid_i = 1'b1;
        @(negedge clk_i);
        chk("load_ready_fall", pix_ready_o, 0);
        chk("load_en_gated", load_en_o, 0);
        chk("load_busy_after", busy_o, (abort_at > 0) ? 0 : 1);
        pix_valid_i = 1'b0;
    endtask

    // Streams results; abort_at aborts on that sample, start_at pulses start at that sample.
    task automatic drain_frame(input int pct, input int abort_at, input int start_at);
        int k = 0;
        int tail = 0;
        int cyc = 0;
        int er = 0;
        int ec = 0;
        int pr = 0;
        int pc = 0;
        bit ps = 0;
        bit pl = 0;
        bit pab = 0;
        bit st_done = 0;
        bit ns;
        logic [12:0] pv = '0;
        logic [12:0] nv;
        while (tail < 3 && cyc < 1000) begin
            @(posedge clk_i); #1;
            ns = (k < NOUT) && !pab && (k == 0 || $urandom_range(0, 99) < pct);
            nv = 13'($urandom);
            dp_save_i = ns;
            dp_e_i    = nv;
            abort_i   = ns && (k == abort_at);
            start_i   = !st_done && (k == start_at);
            if (start_i) st_done = 1;
            @(negedge clk_i);
            chk("drain_ready", pix_ready_o, 0);
            chk("drain_valid", out_valid_o, ps);
            chk("drain_last", out_last_o, ps && pl);
            if (ps) begin
                chk("drain_data", out_data_o, pv);
                chk("drain_row", out_row_o, pr);
                chk("drain_col", out_col_o, pc);
            end
            chk("drain_frame_done", frame_done_o, (tail == 2) && !pab);
            if (tail == 2 || (pab && tail == 1)) chk("drain_idle", busy_o, 0);
            if (abort_i) pab = 1;
            ps = ns && !abort_i;
            if (ps) begin
                pv = nv;
                pr = er;
                pc = ec;
                pl = (k == NOUT - 1);
                k++;
                if (ec == OW - 1) begin
                    ec = 0;
                    er++;
                end else begin
                    ec++;
                end
            end
            if (k == NOUT || pab) tail++;
            cyc++;
        end
        chk("drain_bound", tail, 3);
        @(posedge clk_i); #1;
        dp_save_i = 1'b0;
        abort_i   = 1'b0;
        start_i   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int first;

        //            st ab pv ds | rdy le busy ov
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1, 1, 0, 0, 0, 0, 0};  // start+abort in IDLE: abort wins
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 1, 0};
        vecs[5]  = '{0, 0, 1, 0, 1, 1, 1, 0};
        vecs[6]  = '{1, 0, 0, 0, 1, 0, 1, 0};  // start in LOAD ignored
        vecs[7]  = '{0, 1, 1, 0, 1, 1, 1, 0};  // abort: load_en still combinational
        vecs[8]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 0, 0, 0};  // dp_save in IDLE ignored
        vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 0};

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        pix_valid_i = 1'b0;
        dp_save_i   = 1'b0;
        dp_e_i      = '0;

        // Reset held with random inputs.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            start_i     = 1'($urandom);
            abort_i     = 1'($urandom);
            pix_valid_i = 1'($urandom);
            dp_save_i   = 1'($urandom);
            dp_e_i      = 13'($urandom);
            @(negedge clk_i);
            chk("rst_outputs", {pix_ready_o, load_en_o, busy_o, out_valid_o, out_last_o,
                                frame_done_o, timeout_err_o}, 0);
            chk("rst_data", {out_data_o, out_row_o, out_col_o}, 0);
        end
        start_i     = 1'b0;
        abort_i     = 1'b0;
        pix_valid_i = 1'b0;
        dp_save_i   = 1'b0;
        rst_ni      = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_release_busy", busy_o, 0);
        chk("rst_release_ready", pix_ready_o, 0);

        for (int i = 0; i < 11; i++) begin
            @(posedge clk_i); #1;
            start_i     = vecs[i].start;
            abort_i     = vecs[i].abort;
            pix_valid_i = vecs[i].pv;
            dp_save_i   = vecs[i].ds;
            dp_e_i      = 13'(i);
            @(negedge clk_i);
            chk("vec_ready", pix_ready_o, vecs[i].exp_ready);
            chk("vec_load_en", load_en_o, vecs[i].exp_le);
            chk("vec_busy", busy_o, vecs[i].exp_busy);
            chk("vec_out_valid", out_valid_o, vecs[i].exp_ov);
            chk("vec_frame_done", frame_done_o, 0);
        end
        @(posedge clk_i); #1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        pix_valid_i = 1'b0;
        dp_save_i   = 1'b0;

        // Full frame, continuous traffic.
        start_frame();
        load_frame(100, -1);
        drain_frame(100, -1, -1);

        // Gapped traffic, start pulsed during DRAIN.
        start_frame();
        load_frame(50, -1);
        drain_frame(50, -1, 3);

        // Abort mid-load, abort mid-drain, then a clean frame.
        start_frame();
        load_frame(50, NLOAD / 2);
        start_frame();
        load_frame(100, -1);
        drain_frame(100, 5, -1);
        start_frame();
        load_frame(100, -1);
        drain_frame(50, -1, -1);

        // Abort coincident with the last accept.
        start_frame();
        load_frame(100, NLOAD);

        // Watchdog timeout, then restart from ERR.
        start_frame();
        load_frame(100, -1);
        chk("timeout_early", timeout_err_o, 0);
        first = -1;
        for (int i = 2; i <= 80; i++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            if (timeout_err_o === 1'b1 && first < 0) first = i;
        end
        chk("timeout_cycle", first, TO + 1);
        chk("err_busy", busy_o, 1);
        chk("err_ready", pix_ready_o, 0);
        start_frame();
        load_frame(100, -1);
        drain_frame(100, -1, -1);

        // Asynchronous reset in DRAIN.
        start_frame();
        load_frame(100, -1);
        @(posedge clk_i); #1;
        dp_save_i = 1'b1;
        dp_e_i    = 13'h0abc;
        @(posedge clk_i); #1;
        dp_save_i = 1'b0;
        chk("mid_drain_valid", out_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_valid", out_valid_o, 0);
        chk("async_rst_busy", busy_o, 0);
        chk("async_rst_data", out_data_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_valid", out_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
